// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the 6502 fetch unit: FSM states, reset vector default
// and the opcode-to-operand-length rule (also used by trace/disassembly logic).
package cpu_fetch_pkg;

    typedef enum logic [2:0] {
        VEC_LO   = 3'd0,
        VEC_HI   = 3'd1,
        VEC_WAIT = 3'd2,
        FETCH_OP = 3'd3,
        FETCH_B1 = 3'd4,
        FETCH_B2 = 3'd5,
        FETCH_B3 = 3'd6,
        HOLD     = 3'd7
    } fetch_state_e;

    localparam logic [15:0] RESET_VEC_DEFAULT = 16'hFFFC;

    localparam logic [7:0] OPC_BRK = 8'h00;
    localparam logic [7:0] OPC_JSR = 8'h20;
    localparam logic [7:0] OPC_RTI = 8'h40;
    localparam logic [7:0] OPC_RTS = 8'h60;

    // Opcode layout is aaa_bbb_cc; bbb selects the addressing mode family.
    function automatic logic [1:0] oplen(input logic [7:0] opc);
        logic [1:0] len;
        len = 2'd0;
        if (opc == OPC_JSR) begin
            len = 2'd2;
        end else if (opc == OPC_BRK) begin
            len = 2'd1;
        end else if ((opc == OPC_RTI) || (opc == OPC_RTS)) begin
            len = 2'd0;
        end else if (opc[2]) begin
            len = opc[3] ? 2'd2 : 2'd1;
        end else if (opc[0]) begin
            len = (opc[4:2] == 3'b110) ? 2'd2 : 2'd1;
        end else if ((opc[4:2] == 3'b000) && opc[7]) begin
            len = 2'd1;
        end else if ((opc[1:0] == 2'b00) && (opc[4:2] == 3'b100)) begin
            len = 2'd1;
        end else begin
            len = 2'd0;
        end
        return len;
    endfunction

endpackage

// File: rtl/cpu_fetch_oplen.sv
// Combinational operand-length decoder: 8-bit opcode in, 0..2 operand bytes out.
module cpu_fetch_oplen
    import cpu_fetch_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic [1:0] len_o
);

    // Pure decode of the opcode byte
    always_comb begin
        len_o = oplen(opcode_i);
    end

endmodule

// File: rtl/cpu_fetch.sv
// 6502 instruction fetch: reset vector load, opcode + operand fetch, valid/ready
// hand-off and PC redirect. Optional HOLD-state prefetch: CPU_FETCH_PREFETCH_EN.
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic [7:0]  ir,
    output logic [7:0]  op_lo,
    output logic [7:0]  op_hi,
    output logic [1:0]  op_len,
    output logic [15:0] instr_pc,
    output logic        valid,
    input  logic        ready,
    input  logic        jump_en,
    input  logic [15:0] jump_addr
);

    fetch_state_e state_q;
    logic [15:0]  pc_q;
    logic [15:0]  instr_pc_q;
    logic [7:0]   ir_q;
    logic [7:0]   op_lo_q;
    logic [7:0]   op_hi_q;
    logic [1:0]   op_len_q;
    logic         valid_q;

    logic [1:0]   len_s;
    logic         vec_s;
    logic         rd_s;
    logic [15:0]  rd_addr_s;

    cpu_fetch_oplen u_oplen (
        .opcode_i (mem_data),
        .len_o    (len_s)
    );

    // Redirects are only honoured once the vector has been loaded
    always_comb begin
        vec_s = (state_q == VEC_LO) || (state_q == VEC_HI) || (state_q == VEC_WAIT);
    end

    // Read strobe/address decode; a pending redirect suppresses operand reads
    always_comb begin
        rd_s      = 1'b0;
        rd_addr_s = pc_q;
        case (state_q)
            VEC_LO: begin
                rd_s      = 1'b1;
                rd_addr_s = RESET_VEC;
            end
            VEC_HI: begin
                rd_s      = 1'b1;
                rd_addr_s = RESET_VEC + 16'd1;
            end
            FETCH_OP: rd_s = 1'b1;
            FETCH_B1: rd_s = !jump_en && (len_s != 2'd0);
            FETCH_B2: rd_s = !jump_en && (op_len_q == 2'd2);
`ifdef CPU_FETCH_PREFETCH_EN
            HOLD:     rd_s = ready && !jump_en;
`else
            HOLD:     rd_s = 1'b0;
`endif
            default:  rd_s = 1'b0;
        endcase
        mem_rd   = rd_s && !rst;
        mem_addr = mem_rd ? rd_addr_s : 16'h0000;
    end

    // Fetch FSM with all instruction outputs held in registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= VEC_LO;
            pc_q       <= 16'h0000;
            instr_pc_q <= 16'h0000;
            ir_q       <= 8'h00;
            op_lo_q    <= 8'h00;
            op_hi_q    <= 8'h00;
            op_len_q   <= 2'd0;
            valid_q    <= 1'b0;
        end else if (jump_en && !vec_s) begin
            // Any outstanding read data is simply never consumed
            pc_q    <= jump_addr;
            valid_q <= 1'b0;
            state_q <= FETCH_OP;
        end else begin
            case (state_q)
                VEC_LO: state_q <= VEC_HI;
                VEC_HI: begin
                    pc_q[7:0] <= mem_data;
                    state_q   <= VEC_WAIT;
                end
                VEC_WAIT: begin
                    pc_q[15:8] <= mem_data;
                    state_q    <= FETCH_OP;
                end
                FETCH_OP: begin
                    instr_pc_q <= pc_q;
                    pc_q       <= pc_q + 16'd1;
                    state_q    <= FETCH_B1;
                end
                FETCH_B1: begin
                    ir_q     <= mem_data;
                    op_len_q <= len_s;
                    op_lo_q  <= 8'h00;
                    op_hi_q  <= 8'h00;
                    if (len_s == 2'd0) begin
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        pc_q    <= pc_q + 16'd1;
                        state_q <= FETCH_B2;
                    end
                end
                FETCH_B2: begin
                    op_lo_q <= mem_data;
                    if (op_len_q == 2'd1) begin
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        pc_q    <= pc_q + 16'd1;
                        state_q <= FETCH_B3;
                    end
                end
                FETCH_B3: begin
                    op_hi_q <= mem_data;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (ready) begin
                        valid_q <= 1'b0;
`ifdef CPU_FETCH_PREFETCH_EN
                        // Opcode read overlaps the hand-off cycle
                        instr_pc_q <= pc_q;
                        pc_q       <= pc_q + 16'd1;
                        state_q    <= FETCH_B1;
`else
                        state_q    <= FETCH_OP;
`endif
                    end
                end
                default: state_q <= VEC_LO;
            endcase
        end
    end

    assign ir       = ir_q;
    assign op_lo    = op_lo_q;
    assign op_hi    = op_hi_q;
    assign op_len   = op_len_q;
    assign instr_pc = instr_pc_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: memory model, instruction scoreboard and
// read-address log with cycle stamps; honours CPU_FETCH_PREFETCH_EN timing.
module tb_cpu_fetch;

`ifdef CPU_FETCH_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  ir;
    logic [7:0]  op_lo;
    logic [7:0]  op_hi;
    logic [1:0]  op_len;
    logic [15:0] instr_pc;
    logic        valid;
    logic        ready;
    logic        jump_en;
    logic [15:0] jump_addr;

    logic [7:0]  mem [0:65535];
    logic [41:0] sb [$];
    logic [15:0] rd_addr_log [$];
    int          rd_cyc_log [$];
    int          cyc;
    int          checks;
    int          failures;

    cpu_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .ir        (ir),
        .op_lo     (op_lo),
        .op_hi     (op_hi),
        .op_len    (op_len),
        .instr_pc  (instr_pc),
        .valid     (valid),
        .ready     (ready),
        .jump_en   (jump_en),
        .jump_addr (jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    function automatic int find_rd(input logic [15:0] a);
        for (int i = 0; i < rd_addr_log.size(); i++) begin
            if (rd_addr_log[i] == a) return rd_cyc_log[i];
        end
        return -1;
    endfunction

    // One clock: log reads and retire handshakes against the scoreboard
    task automatic tick();
        logic [41:0] exp;
        @(negedge clk);
        if (mem_rd && !rst) begin
            rd_addr_log.push_back(mem_addr);
            rd_cyc_log.push_back(cyc);
        end
        if (valid && ready && !rst) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got ir=%h pc=%h expected no instruction", ir, instr_pc);
            end else begin
                exp = sb.pop_front();
                if ({ir, op_len, op_lo, op_hi, instr_pc} !== exp) begin
                    failures++;
                    $display("FAIL sb_instr got ir/len/lo/hi/pc=%h/%0d/%h/%h/%h expected %h/%0d/%h/%h/%h",
                             ir, op_len, op_lo, op_hi, instr_pc,
                             exp[41:34], exp[33:32], exp[31:24], exp[23:16], exp[15:0]);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        ready = 1'b0;
        jump_en = 1'b0;
        jump_addr = 16'h0000;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        rd_addr_log.delete();
        rd_cyc_log.delete();
        sb.delete();
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        while (!valid && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (!valid) begin
            failures++;
            $display("FAIL wait_valid timeout got valid=%b expected 1", valid);
        end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain timeout got %0d pending expected 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        mem[16'h1234] = 8'hEA;
        ready = 1'b0;
        jump_en = 1'b0;
        jump_addr = 16'h0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_rd, mem_addr, valid} !== 18'd0) begin
            failures++;
            $display("FAIL reset_bus got rd=%b addr=%h valid=%b expected 0/0000/0", mem_rd, mem_addr, valid);
        end
        checks++;
        if ({ir, op_lo, op_hi, op_len, instr_pc} !== 42'd0) begin
            failures++;
            $display("FAIL reset_outputs got ir=%h lo=%h hi=%h len=%0d pc=%h expected all 0",
                     ir, op_lo, op_hi, op_len, instr_pc);
        end
        rst = 1'b0;
        cyc = 0;
        sb.push_back({8'hEA, 2'd0, 8'h00, 8'h00, 16'h1234});
        wait_valid(20);
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL reset_valid_cycle got %0d expected 5", cyc);
        end
        checks++;
        if (rd_addr_log.size() != 3 || find_rd(16'hFFFC) != 0 || find_rd(16'hFFFD) != 1 || find_rd(16'h1234) != 3) begin
            failures++;
            $display("FAIL reset_reads got n=%0d FFFC@%0d FFFD@%0d 1234@%0d expected n=3 at 0/1/3",
                     rd_addr_log.size(), find_rd(16'hFFFC), find_rd(16'hFFFD), find_rd(16'h1234));
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL reset_transfer got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic load_program();
        mem[16'h1234] = 8'hA9; mem[16'h1235] = 8'h55;
        mem[16'h1236] = 8'h8D; mem[16'h1237] = 8'h00; mem[16'h1238] = 8'h02;
        mem[16'h1239] = 8'h4C; mem[16'h123A] = 8'h34; mem[16'h123B] = 8'h12;
    endtask

    task automatic test_operands();
        load_program();
        do_reset();
        sb.push_back({8'hA9, 2'd1, 8'h55, 8'h00, 16'h1234});
        sb.push_back({8'h8D, 2'd2, 8'h00, 8'h02, 16'h1236});
        sb.push_back({8'h4C, 2'd2, 8'h34, 8'h12, 16'h1239});
        ready = 1'b1;
        drain(80);
        ready = 1'b0;
        checks++;
        if (find_rd(16'h1236) != 7 - PF || find_rd(16'h1239) != 12 - 2 * PF) begin
            failures++;
            $display("FAIL operands_throughput got 1236@%0d 1239@%0d expected %0d/%0d",
                     find_rd(16'h1236), find_rd(16'h1239), 7 - PF, 12 - 2 * PF);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        int c;
        load_program();
        do_reset();
        sb.push_back({8'hA9, 2'd1, 8'h55, 8'h00, 16'h1234});
        wait_valid(20);
        checks++;
        if (cyc != 6) begin
            failures++;
            $display("FAIL bp_valid_cycle got %0d expected 6", cyc);
        end
        n0 = rd_addr_log.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({valid, ir, op_len, op_lo, op_hi, instr_pc} !== {1'b1, 8'hA9, 2'd1, 8'h55, 8'h00, 16'h1234}) begin
                failures++;
                $display("FAIL bp_hold got valid=%b ir=%h len=%0d lo=%h hi=%h pc=%h expected 1/A9/1/55/00/1234",
                         valid, ir, op_len, op_lo, op_hi, instr_pc);
            end
        end
        checks++;
        if (rd_addr_log.size() != n0) begin
            failures++;
            $display("FAIL bp_no_read got %0d reads expected %0d", rd_addr_log.size(), n0);
        end
        c = cyc;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0 || find_rd(16'h1236) != c + 1 - PF) begin
            failures++;
            $display("FAIL bp_release got pending=%0d 1236@%0d expected 0/%0d",
                     sb.size(), find_rd(16'h1236), c + 1 - PF);
        end
    endtask

    task automatic test_jump_mid_fetch();
        load_program();
        mem[16'h3000] = 8'hEA;
        do_reset();
        sb.push_back({8'hA9, 2'd1, 8'h55, 8'h00, 16'h1234});
        sb.push_back({8'hEA, 2'd0, 8'h00, 8'h00, 16'h3000});
        ready = 1'b1;
        while (cyc < 9 - PF) tick();
        jump_en = 1'b1;
        jump_addr = 16'h3000;
        tick();
        jump_en = 1'b0;
        drain(40);
        ready = 1'b0;
        checks++;
        if (find_rd(16'h3000) != 10 - PF || find_rd(16'h1239) != -1) begin
            failures++;
            $display("FAIL jump_mid got 3000@%0d 1239@%0d expected %0d/-1",
                     find_rd(16'h3000), find_rd(16'h1239), 10 - PF);
        end
    endtask

    task automatic test_jump_with_transfer();
        int c;
        mem[16'h1234] = 8'hEA;
        mem[16'h5000] = 8'hE8;
        do_reset();
        wait_valid(20);
        sb.push_back({8'hEA, 2'd0, 8'h00, 8'h00, 16'h1234});
        sb.push_back({8'hE8, 2'd0, 8'h00, 8'h00, 16'h5000});
        c = cyc;
        ready = 1'b1;
        jump_en = 1'b1;
        jump_addr = 16'h5000;
        tick();
        jump_en = 1'b0;
        drain(30);
        ready = 1'b0;
        checks++;
        if (find_rd(16'h5000) != c + 1 || find_rd(16'h1235) != -1) begin
            failures++;
            $display("FAIL jump_xfer got 5000@%0d 1235@%0d expected %0d/-1",
                     find_rd(16'h5000), find_rd(16'h1235), c + 1);
        end
    endtask

    task automatic test_pc_wrap();
        int c;
        mem[16'h1234] = 8'hEA;
        mem[16'hFFFE] = 8'hAD;
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        mem[16'h0001] = 8'hEA;
        do_reset();
        wait_valid(20);
        sb.push_back({8'hAD, 2'd2, 8'h11, 8'h22, 16'hFFFE});
        sb.push_back({8'hEA, 2'd0, 8'h00, 8'h00, 16'h0001});
        c = cyc;
        jump_en = 1'b1;
        jump_addr = 16'hFFFE;
        tick();
        jump_en = 1'b0;
        ready = 1'b1;
        drain(40);
        ready = 1'b0;
        checks++;
        if (find_rd(16'hFFFF) != c + 2 || find_rd(16'h0000) != c + 3 || find_rd(16'h0001) != c + 6 - PF) begin
            failures++;
            $display("FAIL pc_wrap got FFFF@%0d 0000@%0d 0001@%0d expected %0d/%0d/%0d",
                     find_rd(16'hFFFF), find_rd(16'h0000), find_rd(16'h0001), c + 2, c + 3, c + 6 - PF);
        end
    endtask

    task automatic test_oplen_table();
        logic [7:0]  opc_tab [24];
        logic [1:0]  len_tab [24];
        logic [15:0] a;
        logic [7:0]  lo;
        logic [7:0]  hi;
        opc_tab = '{8'h00, 8'h20, 8'h40, 8'h60, 8'hA9, 8'hAD, 8'hEA, 8'h10, 8'hA2, 8'hA0, 8'h85, 8'hB1,
                    8'h9D, 8'h0A, 8'h6C, 8'hBE, 8'hA1, 8'h95, 8'hB9, 8'h02, 8'h03, 8'h80, 8'h08, 8'h2C};
        len_tab = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                    2'd2, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
        mem[16'h1234] = 8'hEA;
        do_reset();
        wait_valid(20);
        a = 16'h4000;
        for (int i = 0; i < 24; i++) begin
            lo = (len_tab[i] != 2'd0) ? (8'h80 | 8'(i)) : 8'h00;
            hi = (len_tab[i] == 2'd2) ? (8'hC0 | 8'(i)) : 8'h00;
            mem[a] = opc_tab[i];
            if (len_tab[i] != 2'd0) mem[a + 16'd1] = lo;
            if (len_tab[i] == 2'd2) mem[a + 16'd2] = hi;
            sb.push_back({opc_tab[i], len_tab[i], lo, hi, a});
            a = a + 16'd1 + 16'(len_tab[i]);
        end
        jump_en = 1'b1;
        jump_addr = 16'h4000;
        tick();
        jump_en = 1'b0;
        ready = 1'b1;
        drain(300);
        ready = 1'b0;
    endtask

    task automatic test_async_reset();
        mem[16'h1234] = 8'hEA;
        do_reset();
        wait_valid(20);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, mem_rd, ir, instr_pc} !== 26'd0) begin
            failures++;
            $display("FAIL async_reset got valid=%b rd=%b ir=%h pc=%h expected 0/0/00/0000",
                     valid, mem_rd, ir, instr_pc);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        rd_addr_log.delete();
        rd_cyc_log.delete();
        tick();
        tick();
        checks++;
        if (find_rd(16'hFFFC) != 0 || find_rd(16'hFFFD) != 1) begin
            failures++;
            $display("FAIL async_revector got FFFC@%0d FFFD@%0d expected 0/1",
                     find_rd(16'hFFFC), find_rd(16'hFFFD));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst = 1'b1;
        ready = 1'b0;
        jump_en = 1'b0;
        jump_addr = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_operands();
        test_backpressure();
        test_jump_mid_fetch();
        test_jump_with_transfer();
        test_pc_wrap();
        test_oplen_table();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction fetch unit for the 6502 core: loads the reset vector, reads each opcode and its 0–2 operand bytes from the synchronous memory bus, and presents the complete instruction (IR, operands, opcode address) to the decode/execute stage over a valid/ready handshake. It is the producer of `IR` for `CPU_control` and accepts PC redirects (jumps, branches, returns) from the execute stage.

## Interface
- `RESET_VEC`, default 16'hFFFC: address of the low vector byte. The high byte is read from `RESET_VEC+1`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mem_rd` output 1: read strobe.
- `mem_addr` output 16: read address, valid when `mem_rd`=1.
- `mem_data` input 8: read data, valid the cycle after `mem_rd`.
- `ir` output 8: opcode.
- `op_lo` output 8: first operand byte. 0 if `op_len`=0.
- `op_hi` output 8: second operand byte. 0 if `op_len`<2.
- `op_len` output 2: operand byte count, 0..2.
- `instr_pc` output 16: address of the opcode.
- `valid` output 1: instruction outputs are stable and complete.
- `ready` input 1: execute accepts; a transfer happens on `valid && ready`.
- `jump_en` input 1: one-cycle redirect request.
- `jump_addr` input 16: new PC, sampled when `jump_en`=1.

## Operation
- **States:** VEC_LO, VEC_HI, VEC_WAIT, FETCH_OP, FETCH_B1, FETCH_B2, FETCH_B3, HOLD.
- **Vector states:**
  - VEC_LO: `mem_rd`=1, addr=`RESET_VEC`.
  - VEC_HI: pc[7:0]←data; read `RESET_VEC+1`.
  - VEC_WAIT: pc[15:8]←data; no read.
  - `jump_en` is ignored in all three vector states.
- **FETCH_OP:** read pc; `instr_pc`←pc; pc←pc+1.
- **FETCH_B1:** `ir`←data; `op_len`←oplen(data).
  - If `op_len`=0: go to HOLD.
  - Otherwise read pc, pc←pc+1, go to FETCH_B2.
- **FETCH_B2:** `op_lo`←data.
  - If `op_len`=1: go to HOLD.
  - Otherwise read pc, pc+1, go to FETCH_B3.
- **FETCH_B3:** `op_hi`←data; go to HOLD.
- **HOLD:** `valid`=1 and outputs are frozen. On `ready` go to FETCH_OP.
- **oplen(IR = aaa_bbb_cc):**
  - JSR 8'h20 → 2. BRK 8'h00 → 1 (signature byte). RTI 8'h40 and RTS 8'h60 → 0.
  - bbb odd → 1 if bbb[1]=0, else 2.
  - cc=x1: bbb 000/010/100 → 1; bbb 110 → 2.
  - cc=x0, bbb 000, aaa≥100 → 1 (immediate).
  - cc=00, bbb 100 → 1 (relative).
  - All remaining encodings → 0, including invalid opcodes.
- **PC arithmetic:** 16-bit, wraps FFFF→0000. Operand bytes wrap the same way.
- **Redirect:** `jump_en` in any non-vector state does the following:
  - pc←`jump_addr` and next state is FETCH_OP.
  - Any in-flight read data is discarded.
  - `valid` drops the next cycle.
  - If `valid && ready && jump_en` occur together, the transfer completes (execute owns the instruction) and the redirect applies. The old stream is not fetched again.
- **Reset mid-operation:** all state is abandoned immediately and the FSM restarts at VEC_LO.

## Timing
- **Reset values:**
  - `mem_rd`=0, `mem_addr`=0.
  - `ir`, `op_lo`, `op_hi`, `op_len`, `instr_pc` = 0.
  - `valid`=0; FSM=VEC_LO.
- **Outputs:** `mem_rd` and `mem_addr` are decoded from state/pc. All instruction outputs are registered.
- **Reset to first opcode read:** 3 cycles after `rst` deasserts (VEC_LO, VEC_HI, VEC_WAIT), then FETCH_OP.
- **Opcode read to `valid`:** 2 cycles for `op_len` 0, 3 cycles for 1, 4 cycles for 2.
- **Throughput with `ready` held high:** one instruction per 3/4/5 cycles for `op_len` 0/1/2.
- **Jump to first read of `jump_addr`:** 1 cycle.

## Configuration
- **`CPU_FETCH_PREFETCH_EN` defined:**
  - In HOLD, when `ready`=1 and `jump_en`=0, drive `mem_rd`=1 with addr=pc (combinational on `ready`).
  - Set `instr_pc`←pc and pc←pc+1, then go directly to FETCH_B1.
  - This saves one cycle per instruction: 2/3/4-cycle throughput.
- **Undefined:** HOLD never reads memory, and timing is as stated above.

## Structure
- The state encodings, the `RESET_VEC` default and the oplen rules go in the shared `config.vh` header, next to the `ADR_*` constants.
- `cpu_oplen` is a combinational sub-module: 8-bit opcode in, 2-bit length out. It is also reused by the disassembler/trace logic.

## Test plan
- **Reset vector:** mem[FFFC]=34, mem[FFFD]=12, mem[1234]=EA (NOP) → first read at 1234; `valid` with `ir`=EA, `op_len`=0, `instr_pc`=1234.
- **Operand capture:** program A9 55 8D 00 02 4C 34 12 → three instructions with (`ir`, `op_len`, `op_lo`, `op_hi`) = (A9,1,55,00), (8D,2,00,02), (4C,2,34,12), at `instr_pc` 1234, 1236, 1239.
- **Backpressure:** hold `ready`=0 for 5 cycles in HOLD → outputs stable, `mem_rd`=0; `ready`=1 → next opcode read the following cycle (or the same cycle with prefetch).
- **Jump mid-fetch:** `jump_en` with addr 3000 during FETCH_B2 of 8D → in-flight byte discarded, next read at 3000, the 8D instruction never becomes valid.
- **PC wrap:** opcode AD at FFFE → operand reads at FFFF and 0000; next opcode at 0001.
- **Async reset:** assert `rst` during HOLD → `valid`=0 immediately; vector reread at FFFC.
